// File: rtl/hyperbus_tx_pkg.sv
// hyperbus_tx_pkg: shared types for the HyperBus TX serializer.
// FSM states, CA width and the CA byte ordering on the bus.
package hyperbus_tx_pkg;

    localparam int CaW = 48;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        LAT,
        DATA
    } tx_state_e;

    typedef struct packed {
        logic [7:0] d0;
        logic [7:0] d1;
    } byte_pair_t;

    // CA goes out MSB first, one 16-bit slice per bus cycle
    function automatic byte_pair_t ca_pair(
        input logic [CaW-1:0] ca,
        input logic [1:0]     phase
    );
        byte_pair_t p;
        unique case (phase)
            2'd0: begin
                p.d0 = ca[47:40];
                p.d1 = ca[39:32];
            end
            2'd1: begin
                p.d0 = ca[31:24];
                p.d1 = ca[23:16];
            end
            default: begin
                p.d0 = ca[15:8];
                p.d1 = ca[7:0];
            end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/hyperbus_tx_downcnt.sv
// hyperbus_tx_downcnt: loadable down-counter with a zero flag.
// Decrement stops at zero; load has priority over decrement.
module hyperbus_tx_downcnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: load, else step down towards zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hyperbus_tx_serializer.sv
// hyperbus_tx_serializer: CA + write data to DDR byte pairs for DQ/RWDS.
// Optional word counter on tx_words_o: define HYPERBUS_TX_WORDCNT_EN.
module hyperbus_tx_serializer
    import hyperbus_tx_pkg::*;
#(
    parameter  int MaxLat = 15,
    parameter  int BurstW = 8,
    localparam int LW     = $clog2(MaxLat + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [CaW-1:0]    ca_i,
    input  logic [LW-1:0]     latency_i,
    input  logic [BurstW-1:0] burst_len_i,
    output logic              ready_o,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic [15:0]       tx_data_i,
    input  logic [1:0]        tx_strb_i,
    output logic [7:0]        dq_d0_o,
    output logic [7:0]        dq_d1_o,
    output logic              rwds_d0_o,
    output logic              rwds_d1_o,
    output logic              dq_oe_o,
    output logic              rwds_oe_o,
    output logic              clk_en_o,
    output logic              done_o,
    output logic [31:0]       tx_words_o
);

    tx_state_e      state_q, state_d;
    logic [1:0]     phase_q, phase_d;
    logic           fin_q, fin_d;
    logic [CaW-1:0] ca_q;
    logic [LW-1:0]  lat_q;
    logic [LW-1:0]  lat_sat;

    logic           ready_q, ready_d;
    logic           tx_ready_q, tx_ready_d;
    logic [7:0]     dq0_q, dq0_d;
    logic [7:0]     dq1_q, dq1_d;
    logic           rw0_q, rw0_d;
    logic           rw1_q, rw1_d;
    logic           dq_oe_q, dq_oe_d;
    logic           rwds_oe_q, rwds_oe_d;
    logic           clk_en_q, clk_en_d;
    logic           done_q, done_d;

    logic           start_ok;
    logic           hs;
    logic           ca_last;
    logic           lat_load;
    logic           lat_zero;
    logic           burst_zero;
    byte_pair_t     ca_pr;

    assign start_ok = start_i & ready_q;
    assign hs       = tx_valid_i & tx_ready_q;
    assign ca_last  = (state_q == CMD) && (phase_q == 2'd2);
    assign lat_load = ca_last && !ca_q[47];
    assign ca_pr    = ca_pair(ca_q, phase_q);

    // clamp requested latency into 1..MaxLat
    always_comb begin
        lat_sat = latency_i;
        if (latency_i == '0) begin
            lat_sat = LW'(1);
        end else if (latency_i > LW'(MaxLat)) begin
            lat_sat = LW'(MaxLat);
        end
    end

    hyperbus_tx_downcnt #(
        .W (LW)
    ) u_lat_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (lat_load),
        .val_i  (lat_q - LW'(1)),
        .dec_i  (state_q == LAT),
        .zero_o (lat_zero)
    );

    hyperbus_tx_downcnt #(
        .W (BurstW)
    ) u_burst_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (start_ok),
        .val_i  (burst_len_i),
        .dec_i  (hs),
        .zero_o (burst_zero)
    );

    // capture the request when it is accepted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ca_q  <= '0;
            lat_q <= LW'(1);
        end else if (start_ok) begin
            ca_q  <= ca_i;
            lat_q <= lat_sat;
        end
    end

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            fin_q   <= fin_d;
        end
    end

    // next-state logic; fin_d marks a completed transaction
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        fin_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = CMD;
                    phase_d = 2'd0;
                end
            end
            CMD: begin
                if (phase_q == 2'd2) begin
                    phase_d = 2'd0;
                    fin_d   = ca_q[47];
                    state_d = ca_q[47] ? IDLE : LAT;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            LAT: begin
                if (lat_zero) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (hs && burst_zero) begin
                    state_d = IDLE;
                    fin_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // output decisions for next cycle; DQ/RWDS hold unless driven
    always_comb begin
        dq0_d      = dq0_q;
        dq1_d      = dq1_q;
        rw0_d      = rw0_q;
        rw1_d      = rw1_q;
        dq_oe_d    = 1'b0;
        rwds_oe_d  = 1'b0;
        clk_en_d   = 1'b0;
        done_d     = fin_q;
        ready_d    = (state_d == IDLE);
        tx_ready_d = (state_d == DATA);
        unique case (state_q)
            IDLE: begin
                dq0_d = '0;
                dq1_d = '0;
                rw0_d = 1'b0;
                rw1_d = 1'b0;
            end
            CMD: begin
                dq0_d    = ca_pr.d0;
                dq1_d    = ca_pr.d1;
                rw0_d    = 1'b0;
                rw1_d    = 1'b0;
                dq_oe_d  = 1'b1;
                clk_en_d = 1'b1;
            end
            LAT: begin
                clk_en_d = 1'b1;
            end
            DATA: begin
                dq_oe_d   = 1'b1;
                rwds_oe_d = 1'b1;
                if (hs) begin
                    dq0_d    = tx_data_i[15:8];
                    dq1_d    = tx_data_i[7:0];
                    rw0_d    = ~tx_strb_i[1];
                    rw1_d    = ~tx_strb_i[0];
                    clk_en_d = 1'b1;
                end
            end
            default: begin
                dq0_d = '0;
                dq1_d = '0;
            end
        endcase
    end

    // output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q    <= 1'b1;
            tx_ready_q <= 1'b0;
            dq0_q      <= '0;
            dq1_q      <= '0;
            rw0_q      <= 1'b0;
            rw1_q      <= 1'b0;
            dq_oe_q    <= 1'b0;
            rwds_oe_q  <= 1'b0;
            clk_en_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            tx_ready_q <= tx_ready_d;
            dq0_q      <= dq0_d;
            dq1_q      <= dq1_d;
            rw0_q      <= rw0_d;
            rw1_q      <= rw1_d;
            dq_oe_q    <= dq_oe_d;
            rwds_oe_q  <= rwds_oe_d;
            clk_en_q   <= clk_en_d;
            done_q     <= done_d;
        end
    end

`ifdef HYPERBUS_TX_WORDCNT_EN
    logic [31:0] words_q;

    // running count of accepted data words
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            words_q <= '0;
        end else if (hs) begin
            words_q <= words_q + 32'd1;
        end
    end

    assign tx_words_o = words_q;
`else
    assign tx_words_o = 32'h0;
`endif

    assign ready_o    = ready_q;
    assign tx_ready_o = tx_ready_q;
    assign dq_d0_o    = dq0_q;
    assign dq_d1_o    = dq1_q;
    assign rwds_d0_o  = rw0_q;
    assign rwds_d1_o  = rw1_q;
    assign dq_oe_o    = dq_oe_q;
    assign rwds_oe_o  = rwds_oe_q;
    assign clk_en_o   = clk_en_q;
    assign done_o     = done_q;

endmodule
